// File: rtl/axi_sram_rd_slave.sv
// AXI4 read-side slave front-end for a synchronous on-chip SRAM.
// Accepts one AR burst at a time. It issues one SRAM word read per beat,
// buffers the returned words in a 2-entry queue and presents them on the
// R channel.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   ar*_i / arready_o   read address channel (arsize_i ignored, 4-byte beats)
//   r*_o / rready_i     read data channel (rresp_o always OKAY)
//   sram_ceb_o          SRAM chip enable, active low, asserted on each issue
//   sram_web_o          SRAM write enable, active low, tied inactive
//   sram_a_o            SRAM word address, holds its last value between issues
//   sram_do_i           SRAM read data, valid the cycle after ceb=0
module axi_sram_rd_slave #(
  parameter int IDS_W   = 8,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDS_W-1:0]   arid_i,
  input  logic [31:0]        araddr_i,
  input  logic [3:0]         arlen_i,
  input  logic [2:0]         arsize_i,
  input  logic [1:0]         arburst_i,
  input  logic               arvalid_i,
  output logic               arready_o,
  output logic [IDS_W-1:0]   rid_o,
  output logic [DATA_W-1:0]  rdata_o,
  output logic [1:0]         rresp_o,
  output logic               rlast_o,
  output logic               rvalid_o,
  input  logic               rready_i,
  output logic               sram_ceb_o,
  output logic               sram_web_o,
  output logic [SRAM_AW-1:0] sram_a_o,
  input  logic [DATA_W-1:0]  sram_do_i
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  localparam logic [SRAM_AW-1:0] ADDR_ONE = SRAM_AW'(1);

  state_t               state_q;
  logic [IDS_W-1:0]     id_q;
  logic [SRAM_AW-1:0]   addr_q;       // word address of the next issue
  logic [SRAM_AW-1:0]   addr_d;
  logic [SRAM_AW-1:0]   a_q;          // address of the most recent issue
  logic [3:0]           len_q;
  logic [1:0]           burst_q;
  logic [4:0]           issued_q;     // 0..16 issues per burst
  logic                 inflight_q;   // an SRAM read returns this cycle
  logic [3:0]           inflight_idx_q;

  // 2-entry output queue, each entry carries its beat index for rlast
  logic [DATA_W-1:0]    data_q [2];
  logic [3:0]           idx_q  [2];
  logic                 wr_q;
  logic                 rd_q;
  logic [1:0]           count_q;
  logic [1:0]           count_d;

  logic                 pop;
  logic                 push;
  logic                 issue;
  logic [2:0]           occ;

  logic                 unused_bits;
  assign unused_bits = ^{arsize_i, araddr_i[31:SRAM_AW+2], araddr_i[1:0]};

  // Word-address step after an issue. WRAP only wraps for 2/4/8/16-beat
  // bursts; other lengths fall back to INCR, as does the reserved encoding.
  function automatic logic [SRAM_AW-1:0] next_addr(
    input logic [SRAM_AW-1:0] a,
    input logic [3:0]         len,
    input logic [1:0]         burst
  );
    logic [SRAM_AW-1:0] inc;
    logic [SRAM_AW-1:0] mask;
    inc  = a + ADDR_ONE;
    mask = {{(SRAM_AW-4){1'b0}}, len};
    case (burst)
      2'b00:   next_addr = a;
      2'b10: begin
        if (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)
          next_addr = (a & ~mask) | (inc & mask);
        else
          next_addr = inc;
      end
      default: next_addr = inc;
    endcase
  endfunction

  assign pop  = (count_q != 2'd0) && rready_i;
  assign push = inflight_q;

  // Slots already committed (stored + returning) minus the one leaving now
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == S_BURST) &&
                 (issued_q < ({1'b0, len_q} + 5'd1)) &&
                 (occ < 3'd2);

  assign addr_d = next_addr(addr_q, len_q, burst_q);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  assign arready_o  = (state_q == S_IDLE);
  assign rvalid_o   = (count_q != 2'd0);
  assign rdata_o    = data_q[rd_q];
  assign rlast_o    = (count_q != 2'd0) && (idx_q[rd_q] == len_q);
  assign rid_o      = id_q;
  assign rresp_o    = 2'b00;
  assign sram_ceb_o = ~issue;
  assign sram_web_o = 1'b1;
  assign sram_a_o   = issue ? addr_q : a_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      id_q           <= '0;
      addr_q         <= '0;
      a_q            <= '0;
      len_q          <= '0;
      burst_q        <= '0;
      issued_q       <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      data_q[0]      <= '0;
      data_q[1]      <= '0;
      idx_q[0]       <= '0;
      idx_q[1]       <= '0;
      wr_q           <= 1'b0;
      rd_q           <= 1'b0;
      count_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arvalid_i) begin
            id_q     <= arid_i;
            addr_q   <= araddr_i[SRAM_AW+1:2];
            len_q    <= arlen_i;
            burst_q  <= arburst_i;
            issued_q <= '0;
            state_q  <= S_BURST;
          end
        end
        S_BURST: begin
          if (pop && rlast_o) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Issue stage: address advance and tagging of the returning read
      if (issue) begin
        addr_q         <= addr_d;
        a_q            <= addr_q;
        issued_q       <= issued_q + 5'd1;
        inflight_idx_q <= issued_q[3:0];
      end
      inflight_q <= issue;

      // Capture stage: SRAM data lands in the queue one cycle after issue
      if (push) begin
        data_q[wr_q] <= sram_do_i;
        idx_q[wr_q]  <= inflight_idx_q;
        wr_q         <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Self-checking bench for axi_sram_rd_slave: directed bursts plus a random
// phase, checked against a burst-level reference model of the read stream.
module tb_axi_sram_rd_slave;
  localparam int IDS_W   = 8;
  localparam int DATA_W  = 32;
  localparam int SRAM_AW = 14;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [IDS_W-1:0]   arid_i = '0;
  logic [31:0]        araddr_i = '0;
  logic [3:0]         arlen_i = '0;
  logic [2:0]         arsize_i = 3'b010;
  logic [1:0]         arburst_i = '0;
  logic               arvalid_i = 1'b0;
  logic               arready_o;
  logic [IDS_W-1:0]   rid_o;
  logic [DATA_W-1:0]  rdata_o;
  logic [1:0]         rresp_o;
  logic               rlast_o;
  logic               rvalid_o;
  logic               rready_i = 1'b1;
  logic               sram_ceb_o;
  logic               sram_web_o;
  logic [SRAM_AW-1:0] sram_a_o;
  logic [DATA_W-1:0]  sram_do_i;

  always #5 clk = ~clk;

  axi_sram_rd_slave #(.IDS_W(IDS_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) dut (
    .clk(clk), .rst(rst),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i),
    .sram_ceb_o(sram_ceb_o), .sram_web_o(sram_web_o), .sram_a_o(sram_a_o),
    .sram_do_i(sram_do_i)
  );

  // Synchronous SRAM model: data appears the cycle after a read enable
  logic [31:0] mem [0:16383];
  logic [31:0] sram_q;
  always @(posedge clk) if (!sram_ceb_o) sram_q <= mem[sram_a_o];
  assign sram_do_i = sram_q;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: the full list of word addresses and beats per burst
  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_beats[$];
  int unsigned exp_addr[$];

  function automatic int unsigned beat_addr(input int unsigned start, input int len,
                                            input logic [1:0] burst, input int i);
    int unsigned n;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      n = len + 1;
      return (start / n) * n + ((start % n) + i) % n;
    end
    return (start + i) % 16384;
  endfunction

  task automatic model_ar(input logic [7:0] id, input logic [31:0] addr,
                          input int len, input logic [1:0] burst);
    int unsigned start;
    int unsigned a;
    beat_t b;
    start = addr[15:2];
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(start, len, burst, i);
      exp_addr.push_back(a);
      b.id = id; b.data = mem[a]; b.last = (i == len);
      exp_beats.push_back(b);
    end
  endtask

  int hs_cyc       = 0;
  int last_pop_cyc = 0;
  int n_issue      = 0;
  int n_pop        = 0;
  int outstanding  = 0;
  int mode         = 0;   // 0: rready=1, 1: random, 2: rready=0

  // rready generator, changes just after each rising edge
  initial begin
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       rready_i = 1'b1;
        1:       rready_i = 1'($urandom_range(0, 1));
        default: rready_i = 1'b0;
      endcase
    end
  end

  // Monitor: issue addresses, occupancy, beats and backpressure stability
  logic              stall_q = 1'b0;
  logic [31:0]       prev_data;
  logic [7:0]        prev_id;
  logic              prev_last;
  beat_t             eb;
  always @(negedge clk) begin
    if (rst) begin
      if (!sram_ceb_o) begin
        n_issue++;
        outstanding++;
        check_eq("sram_web", 64'(sram_web_o), 64'd1);
        if (exp_addr.size() == 0) check_eq("issue_unexpected", 64'(exp_addr.size()), 64'd1);
        else check_eq("sram_a", 64'(sram_a_o), 64'(exp_addr.pop_front()));
      end
      if (rvalid_o && rready_i) begin
        outstanding--;
        n_pop++;
        if (exp_beats.size() == 0) check_eq("beat_unexpected", 64'(exp_beats.size()), 64'd1);
        else begin
          eb = exp_beats.pop_front();
          check_eq("rdata", 64'(rdata_o), 64'(eb.data));
          check_eq("rid",   64'(rid_o),   64'(eb.id));
          check_eq("rlast", 64'(rlast_o), 64'(eb.last));
          check_eq("rresp", 64'(rresp_o), 64'd0);
          if (rlast_o) last_pop_cyc = cyc;
        end
      end
      if (!sram_ceb_o) check_eq("occupancy_le2", 64'(outstanding <= 2), 64'd1);
      if (stall_q) begin
        check_eq("hold_rvalid", 64'(rvalid_o), 64'd1);
        check_eq("hold_rdata",  64'(rdata_o),  64'(prev_data));
        check_eq("hold_rid",    64'(rid_o),    64'(prev_id));
        check_eq("hold_rlast",  64'(rlast_o),  64'(prev_last));
      end
      stall_q   = rvalid_o && !rready_i;
      prev_data = rdata_o;
      prev_id   = rid_o;
      prev_last = rlast_o;
    end
  end

  // Call at posedge+1; returns at posedge+1 of the cycle after the handshake
  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst);
    int w;
    w = 0;
    arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst;
    arsize_i = 3'b010; arvalid_i = 1'b1;
    @(negedge clk);
    while (!arready_o && w < 300) begin @(negedge clk); w++; end
    if (!arready_o) begin
      check_eq("ar_timeout", 64'(arready_o), 64'd1);
      arvalid_i = 1'b0;
      return;
    end
    hs_cyc = cyc;
    model_ar(id, addr, int'(len), burst);
    @(posedge clk); #1;
    arvalid_i = 1'b0;
    arid_i = 8'($urandom);
    araddr_i = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_beats.size() != 0 || !arready_o) && w < 600) begin @(negedge clk); w++; end
    if (w >= 600) check_eq("drain_timeout", 64'(exp_beats.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int i0;
    int p0;
    int w;
    for (int i = 0; i < 16384; i++) mem[i] = (i < 256) ? (32'h1000 + 32'(i)) : $urandom;
    mem[4] = 32'hDEADBEEF;

    // Reset state
    #12;
    check_eq("rst_arready", 64'(arready_o), 64'd1);
    check_eq("rst_rvalid",  64'(rvalid_o),  64'd0);
    check_eq("rst_rlast",   64'(rlast_o),   64'd0);
    check_eq("rst_rid",     64'(rid_o),     64'd0);
    check_eq("rst_rdata",   64'(rdata_o),   64'd0);
    check_eq("rst_ceb",     64'(sram_ceb_o),64'd1);
    check_eq("rst_sram_a",  64'(sram_a_o),  64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single beat latency
    send_ar(8'h12, 32'h0000_0010, 4'd0, 2'b01);
    @(negedge clk);
    check_eq("t1_ceb",    64'(sram_ceb_o), 64'd0);
    check_eq("t1_sram_a", 64'(sram_a_o),   64'd4);
    @(negedge clk);
    @(negedge clk);
    check_eq("t3_rvalid", 64'(rvalid_o), 64'd1);
    check_eq("t3_rdata",  64'(rdata_o),  64'hDEADBEEF);
    check_eq("t3_rlast",  64'(rlast_o),  64'd1);
    check_eq("t3_rid",    64'(rid_o),    64'h12);
    @(negedge clk);
    check_eq("t4_arready", 64'(arready_o), 64'd1);
    @(posedge clk); #1;

    // INCR burst at full rate
    send_ar(8'h21, 32'h0000_0100, 4'd3, 2'b01);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("incr_rvalid", 64'(rvalid_o), 64'd1);
      check_eq("incr_rdata",  64'(rdata_o),  64'(32'h1040 + 32'(i)));
      check_eq("incr_rlast",  64'(rlast_o),  64'(i == 3));
    end
    drain();

    // Backpressure: rready low through T+7
    mode = 2;
    @(posedge clk); #1;
    i0 = n_issue;
    send_ar(8'h34, 32'h0000_0100, 4'd3, 2'b01);
    repeat (7) @(negedge clk);
    #1;
    check_eq("bp_issues",  64'(n_issue - i0), 64'd2);
    check_eq("bp_ceb",     64'(sram_ceb_o),   64'd1);
    check_eq("bp_rvalid",  64'(rvalid_o),     64'd1);
    check_eq("bp_rdata",   64'(rdata_o),      64'h1040);
    mode = 0;
    drain();

    // WRAP 4 beats from word 6
    send_ar(8'h45, 32'h0000_0018, 4'd3, 2'b10);
    drain();

    // FIXED burst with a second request held from T+1
    send_ar(8'h56, 32'h0000_0020, 4'd2, 2'b00);
    send_ar(8'h67, 32'h0000_0040, 4'd0, 2'b01);
    check_eq("overlap_accept_cyc", 64'(hs_cyc), 64'(last_pop_cyc + 1));
    drain();

    // Reset in the middle of a long burst
    p0 = n_pop;
    send_ar(8'h5A, 32'h0000_0200, 4'd7, 2'b01);
    w = 0;
    while (n_pop < p0 + 2 && w < 100) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("mrst_rvalid",  64'(rvalid_o),   64'd0);
    check_eq("mrst_ceb",     64'(sram_ceb_o), 64'd1);
    check_eq("mrst_arready", 64'(arready_o),  64'd1);
    check_eq("mrst_rlast",   64'(rlast_o),    64'd0);
    exp_beats.delete();
    exp_addr.delete();
    outstanding = 0;
    stall_q = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_ar(8'h77, 32'h0000_0100, 4'd3, 2'b01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("post_rst_beat0", 64'(rdata_o), 64'h1040);
    drain();

    // Random bursts with random backpressure
    mode = 1;
    for (int k = 0; k < 40; k++) begin
      send_ar(8'($urandom), $urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("final_model_empty", 64'(exp_beats.size()), 64'd0);
    check_eq("final_rvalid", 64'(rvalid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
